// File: rtl/share_decoder_if.sv
// Handshake bundle between a share producer/consumer and share_decoder.
// The master drives the sharing and out_ready. The slave (the decoder) drives the ready/valid/data returns.
interface share_decoder_if #(
   parameter int security_order = 1,
   parameter int width          = 8
);
   logic                                in_valid;
   logic                                in_ready;
   logic [(security_order+1)*width-1:0] in_shares;
   logic                                out_valid;
   logic                                out_ready;
   logic [width-1:0]                    out_data;

   modport master (
      output in_valid, in_shares, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_shares, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/share_decoder.sv
// Unmasks a (d+1)-share boolean sharing by folding one share per cycle into an accumulator.
// Each share is zeroized as soon as it has been consumed.
//
// state | meaning
// IDLE  | waiting for a sharing; share register and acc are all zero
// ACCUM | folding share[cnt] into acc, one share per cycle, d+1 cycles
// OUT   | acc presented on out_data until out_ready
module share_decoder #(
   parameter int security_order = 1,
   parameter int width          = 8
) (
   input logic           clk,
   input logic           rst_n,
   share_decoder_if.slave bus
);
   localparam int n     = security_order + 1;
   localparam int cnt_w = (n > 1) ? $clog2(n) : 1;
   localparam logic [cnt_w-1:0] cnt_last = cnt_w'(security_order);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      OUT   = 2'd2
   } state_t;

   state_t                  state_q;
   state_t                  state_d;
   logic [n-1:0][width-1:0] share_q;
   logic [width-1:0]        acc_q;
   logic [cnt_w-1:0]        cnt_q;
   logic                    cnt_done;

   assign cnt_done     = (cnt_q == cnt_last);
   assign bus.out_data = acc_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_d = ACCUM;
         end
         ACCUM: begin
            if (cnt_done) state_d = OUT;
         end
         OUT: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Only share[cnt] ever meets acc, so no two unconsumed shares are combined.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         share_q <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  share_q <= bus.in_shares;
                  cnt_q   <= '0;
               end
            end
            ACCUM: begin
               if (cnt_q == '0) begin
                  acc_q <= share_q[cnt_q];
               end else begin
                  acc_q <= acc_q ^ share_q[cnt_q];
               end
               share_q[cnt_q] <= '0;
               cnt_q          <= cnt_done ? '0 : cnt_q + 1'b1;
            end
            OUT: begin
               if (bus.out_ready) acc_q <= '0;
            end
            default: begin
               share_q <= '0;
               acc_q   <= '0;
               cnt_q   <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_share_decoder.sv
// Directed and randomized checks of share_decoder for d = 1, 2, 3 against an XOR-of-bytes model.
module tb_share_decoder;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        iv   [1:3];
   logic        ordy [1:3];
   logic [31:0] ish  [1:3];
   logic        irdy [1:3];
   logic        ovld [1:3];
   logic [7:0]  odat [1:3];

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   bit chk_en = 1'b0;

   share_decoder_if #(.security_order(1), .width(8)) b1 ();
   share_decoder_if #(.security_order(2), .width(8)) b2 ();
   share_decoder_if #(.security_order(3), .width(8)) b3 ();

   assign b1.in_valid  = iv[1];
   assign b1.in_shares = ish[1][15:0];
   assign b1.out_ready = ordy[1];
   assign irdy[1]      = b1.in_ready;
   assign ovld[1]      = b1.out_valid;
   assign odat[1]      = b1.out_data;

   assign b2.in_valid  = iv[2];
   assign b2.in_shares = ish[2][23:0];
   assign b2.out_ready = ordy[2];
   assign irdy[2]      = b2.in_ready;
   assign ovld[2]      = b2.out_valid;
   assign odat[2]      = b2.out_data;

   assign b3.in_valid  = iv[3];
   assign b3.in_shares = ish[3];
   assign b3.out_ready = ordy[3];
   assign irdy[3]      = b3.in_ready;
   assign ovld[3]      = b3.out_valid;
   assign odat[3]      = b3.out_data;

   share_decoder #(.security_order(1), .width(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   share_decoder #(.security_order(2), .width(8)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
   share_decoder #(.security_order(3), .width(8)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

   function automatic logic [7:0] xor_model(input int d, input logic [31:0] sh);
      logic [7:0] r;
      r = 8'h00;
      for (int k = 0; k <= d; k++) r = r ^ sh[k*8 +: 8];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle; any decoder sitting in IDLE must hold nothing but zeros.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (chk_en) begin
         if (irdy[1]) chk("zero_d1", 32'(u1.share_q) | 32'(u1.acc_q) | 32'(odat[1]), 0);
         if (irdy[2]) chk("zero_d2", 32'(u2.share_q) | 32'(u2.acc_q) | 32'(odat[2]), 0);
         if (irdy[3]) chk("zero_d3", 32'(u3.share_q) | 32'(u3.acc_q) | 32'(odat[3]), 0);
      end
   endtask

   // Full transaction on decoder d=i; out_ready is withheld for 'hold' OUT cycles.
   task automatic xact(input int i, input logic [31:0] sh, input int hold, input string tag);
      logic [7:0] exp_d;
      int         lat;
      exp_d = xor_model(i, sh);
      chk({tag, "_rdy_pre"}, irdy[i], 1);
      iv[i]   = 1'b1;
      ish[i]  = sh;
      ordy[i] = 1'b0;
      tick();
      lat = 0;
      while (!ovld[i] && lat < 20) begin
         chk({tag, "_rdy_accum"}, irdy[i], 0);
         iv[i]   = 1'($urandom_range(0, 1));
         ish[i]  = $urandom;
         ordy[i] = 1'($urandom_range(0, 1));
         tick();
         lat++;
      end
      chk({tag, "_latency"}, lat, i + 1);
      ordy[i] = 1'b0;
      for (int h = 0; h < hold; h++) begin
         chk({tag, "_hold_valid"}, ovld[i], 1);
         chk({tag, "_hold_data"}, odat[i], exp_d);
         chk({tag, "_rdy_out"}, irdy[i], 0);
         iv[i]  = ~h[0];
         ish[i] = 32'h0000_00FF;
         tick();
      end
      iv[i] = 1'b0;
      chk({tag, "_valid"}, ovld[i], 1);
      chk({tag, "_data"}, odat[i], exp_d);
      ordy[i] = 1'b1;
      tick();
      ordy[i] = 1'b0;
      chk({tag, "_rdy_post"}, irdy[i], 1);
      chk({tag, "_valid_post"}, ovld[i], 0);
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] exp_b;
      int got;
      int pushed;
      int last;
      int guard;

      rst_n = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         iv[i]   = 1'b0;
         ordy[i] = 1'b0;
         ish[i]  = '0;
      end
      repeat (3) tick();
      for (int i = 1; i <= 3; i++) begin
         chk("reset_in_ready", irdy[i], 1);
         chk("reset_out_valid", ovld[i], 0);
         chk("reset_out_data", odat[i], 0);
      end
      rst_n  = 1'b1;
      chk_en = 1'b1;
      tick();

      xact(1, 32'h0000_3CA5, 0, "d1_a5_3c");
      xact(2, 32'h00FF_F00F, 0, "d2_0f_f0_ff");
      xact(1, 32'h0000_3412, 5, "d1_stall");
      xact(1, $urandom, 0, "d1_after_stall");

      for (int i = 1; i <= 3; i++) ordy[i] = 1'b1;
      repeat (3) begin
         tick();
         for (int i = 1; i <= 3; i++) begin
            chk("idle_out_ready_valid", ovld[i], 0);
            chk("idle_out_ready_rdy", irdy[i], 1);
         end
      end
      for (int i = 1; i <= 3; i++) ordy[i] = 1'b0;

      // Reset lands on the second ACCUM cycle of the d=3 decoder.
      iv[3]  = 1'b1;
      ish[3] = $urandom | 32'h0101_0101;
      tick();
      iv[3] = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rst_mid_in_ready", irdy[3], 1);
      chk("rst_mid_out_valid", ovld[3], 0);
      chk("rst_mid_acc", 32'(u3.acc_q), 0);
      chk("rst_mid_shares", u3.share_q, 0);
      repeat (4) begin
         tick();
         chk("rst_mid_no_partial", ovld[3], 0);
      end
      xact(3, 32'h0804_0201, 0, "d3_after_rst");

      for (int n = 0; n < 12; n++) begin
         for (int i = 1; i <= 3; i++) begin
            xact(i, $urandom, $urandom_range(0, 3), "rand");
         end
      end

      // Back-to-back traffic on d=1 with in_valid and out_ready pinned high.
      got    = 0;
      pushed = 0;
      last   = -1;
      guard  = 0;
      ordy[1] = 1'b1;
      while (got < 100 && guard < 1000) begin
         if (ovld[1]) begin
            chk("b2b_queue_nonempty", q.size() > 0, 1);
            exp_b = (q.size() > 0) ? q.pop_front() : 8'h00;
            chk("b2b_data", odat[1], exp_b);
            if (last >= 0) chk("b2b_spacing", cyc - last, 4);
            last = cyc;
            got++;
         end
         if (pushed < 100) begin
            ish[1] = $urandom;
            iv[1]  = 1'b1;
            if (irdy[1]) begin
               q.push_back(xor_model(1, ish[1]));
               pushed++;
            end
         end else begin
            iv[1] = 1'b0;
         end
         tick();
         guard++;
      end
      chk("b2b_count", got, 100);
      iv[1]   = 1'b0;
      ordy[1] = 1'b0;
      repeat (2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
